// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding and the output-arbiter FSM states.
package noc_pkg;

  localparam int unsigned FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_SINGLE = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_BODY   = 2'b10,
    FLIT_TAIL   = 2'b11
  } flit_type_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Caller passes the top FLIT_TYPE_W bits of a flit, so this works for any flit width.
  function automatic flit_type_t flit_type(input logic [FLIT_TYPE_W-1:0] type_bits);
    return flit_type_t'(type_bits);
  endfunction

endpackage

// File: rtl/noc_output_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index starting at ptr, wrapping at N.
module rr_picker #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] pick
);

  int unsigned idx;

  // Wrap compares against N explicitly so non-power-of-two N never aliases.
  always_comb begin
    any  = 1'b0;
    pick = '0;
    idx  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && eligible[PW'(idx)]) begin
        any  = 1'b1;
        pick = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output-port arbiter: round-robin per packet, grant held head-to-tail,
// owning FIFO popped on every accepted downstream transfer.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN-1:0]            req,
  input  logic [N_IN-1:0]            fifo_empty,
  input  logic [N_IN*DATA_WIDTH-1:0] fifo_dout,
  output logic [N_IN-1:0]            fifo_rd_en,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_IN-1:0]            grant,
  output logic                       busy
);

  localparam int unsigned PW = $clog2(N_IN);

  arb_state_t            state, state_nx;
  logic [PW-1:0]         owner, ptr, pick;
  logic                  any;
  logic [N_IN-1:0]       eligible;
  logic [DATA_WIDTH-1:0] owner_flit;
  logic                  owner_last;
  logic                  xfer;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      eligible[i] = req[i] & ~fifo_empty[i] &
                    (flit_type(fifo_dout[i*DATA_WIDTH + DATA_WIDTH - 1 -: FLIT_TYPE_W])
                     inside {FLIT_HEAD, FLIT_SINGLE});
    end
  end

  rr_picker #(.N(N_IN)) u_picker (
    .eligible (eligible),
    .ptr      (ptr),
    .any      (any),
    .pick     (pick)
  );

  assign owner_flit = fifo_dout[32'(owner)*DATA_WIDTH +: DATA_WIDTH];
  assign owner_last = flit_type(owner_flit[DATA_WIDTH-1 -: FLIT_TYPE_W])
                      inside {FLIT_TAIL, FLIT_SINGLE};
  assign xfer       = (state == ST_LOCKED) & ~rst & ~fifo_empty[owner] & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (any) state_nx = ST_LOCKED;
      ST_LOCKED: if (xfer && owner_last) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= '0;
      ptr   <= '0;
    end else begin
      if (state == ST_IDLE && any) owner <= pick;
      if (xfer && owner_last) ptr <= (32'(owner) == N_IN - 1) ? '0 : owner + PW'(1);
    end
  end

  // rd_en and out_valid both derive from xfer / ~rst so reset suppresses them combinationally.
  always_comb begin
    fifo_rd_en = '0;
    out_data   = '0;
    out_valid  = 1'b0;
    grant      = '0;
    busy       = 1'b0;
    if (state == ST_LOCKED) begin
      grant[owner]      = 1'b1;
      busy              = 1'b1;
      out_data          = owner_flit;
      out_valid         = ~fifo_empty[owner] & ~rst;
      fifo_rd_en[owner] = xfer;
    end
  end

endmodule
